// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux block: FSM state encoding, mode values
// and the select-width helper.
package scan_mux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t MANUAL = 2'd1;
  localparam state_t SCAN   = 2'd2;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_mux_next.sv
// Circular priority finder: the next enabled channel strictly above cur,
// or the lowest enabled channel with wrap=1 when none exists above.
module scan_mux_next #(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic [CHANNELS-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    nxt,
  output logic                wrap
);

  logic [SEL_W-1:0] lowest;
  logic             found_hi;
  logic             found_lo;

  always_comb begin
    // NOTE: every signal gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    nxt      = '0;
    wrap     = 1'b0;
    lowest   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mask[k] && !found_lo) begin
        lowest   = SEL_W'(k);
        found_lo = 1'b1;
      end
      if (mask[k] && (k > int'(cur)) && !found_hi) begin
        nxt      = SEL_W'(k);
        found_hi = 1'b1;
      end
    end
    if (!found_hi) begin
      nxt  = lowest;
      wrap = found_lo;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Channel multiplexer with manual select and masked auto-scan with dwell.
// Optional registered parity output is enabled by defining SCAN_MUX_PARITY_EN.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int CHANNELS = 16,
  parameter  int DATA_W   = 1,
  parameter  int DWELL_W  = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*DATA_W-1:0] din,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  input  logic [CHANNELS-1:0]        mask,
  input  logic [DWELL_W-1:0]         dwell,
  output logic [DATA_W-1:0]          dout,
  output logic [SEL_W-1:0]           ch_out,
  output logic                       valid,
  output logic                       wrap
`ifdef SCAN_MUX_PARITY_EN
  ,
  output logic                       parity
`endif
);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [SEL_W-1:0]    find_idx, nxt_idx;
  logic                nxt_wrap;
  logic [DATA_W-1:0]   dout_d;
  logic [SEL_W-1:0]    ch_d;
  logic                valid_d, wrap_d;

  function automatic logic [DATA_W-1:0] chan_data(
    input logic [CHANNELS*DATA_W-1:0] bus,
    input logic [SEL_W-1:0]           idx
  );
    chan_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(idx) == k) chan_data = bus[k*DATA_W +: DATA_W];
    end
  endfunction

  always_comb begin
    if (mode == MODE_MANUAL) state_d = MANUAL;
    else if (|mask)          state_d = SCAN;
    else                     state_d = IDLE;
  end

  // Outside SCAN the finder starts from the top index, so its answer is the lowest enabled channel.
  assign find_idx = (state_q == SCAN) ? cur_q : SEL_W'(CHANNELS - 1);

  scan_mux_next #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_next (
    .mask (mask),
    .cur  (find_idx),
    .nxt  (nxt_idx),
    .wrap (nxt_wrap)
  );

  always_comb begin
    cur_d   = '0;
    cnt_d   = '0;
    dwell_d = dwell_q;
    dout_d  = '0;
    ch_d    = '0;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_d)
      MANUAL: begin
        if (int'(sel) < CHANNELS) begin
          dout_d  = chan_data(din, sel);
          ch_d    = sel;
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (state_q != SCAN) begin
          cur_d   = nxt_idx;
          dwell_d = dwell;
        end else if (!mask[cur_q] || (cnt_q == dwell_q)) begin
          // Dwell is latched only here, so a new value applies from this advance on.
          cur_d   = nxt_idx;
          wrap_d  = nxt_wrap;
          dwell_d = dwell;
        end else begin
          cur_d = cur_q;
          cnt_d = cnt_q + 1'b1;
        end
        dout_d  = chan_data(din, cur_d);
        ch_d    = cur_d;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the first branch of the clocked block; all state updates use <=.
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      dout    <= '0;
      ch_out  <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      dout    <= dout_d;
      ch_out  <= ch_d;
      valid   <= valid_d;
      wrap    <= wrap_d;
    end
  end

`ifdef SCAN_MUX_PARITY_EN
  // dout_d is already zero whenever valid_d is low, so parity is zero there too.
  always_ff @(posedge clk) begin
    if (!rst_n) parity <= 1'b0;
    else        parity <= ^dout_d;
  end
`endif

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: table-driven vectors with a scoreboard
// queue, plus a hand-written out-of-range select sequence on a 12-channel copy.
module tb_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        mode;
  logic [3:0]  sel;
  logic [15:0] mask;
  logic [3:0]  dwell;
  logic        dout;
  logic [3:0]  ch_out;
  logic        valid;
  logic        wrap;

  logic [11:0] din12;
  logic [3:0]  sel12;
  logic        dout12;
  logic [3:0]  ch_out12;
  logic        valid12;
  logic        wrap12;

`ifdef SCAN_MUX_PARITY_EN
  logic parity;
  logic parity12;
`endif

  always #5 clk = ~clk;

  scan_mux #(.CHANNELS(16), .DATA_W(1), .DWELL_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .mode   (mode),
    .sel    (sel),
    .mask   (mask),
    .dwell  (dwell),
    .dout   (dout),
    .ch_out (ch_out),
    .valid  (valid),
    .wrap   (wrap)
`ifdef SCAN_MUX_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  scan_mux #(.CHANNELS(12), .DATA_W(1), .DWELL_W(4)) dut12 (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din12),
    .mode   (1'b0),
    .sel    (sel12),
    .mask   (12'h000),
    .dwell  (4'd0),
    .dout   (dout12),
    .ch_out (ch_out12),
    .valid  (valid12),
    .wrap   (wrap12)
`ifdef SCAN_MUX_PARITY_EN
    ,
    .parity (parity12)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] mask;
    logic [3:0]  dwell;
    logic        e_valid;
    logic [3:0]  e_ch;
    logic        e_wrap;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [3:0] ch;
    logic       dout;
    logic       wrap;
    int         idx;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [15:0] din_c   = 16'h3333;
  logic [11:0] din12_c = 12'h333;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic m, input logic [3:0] s,
                              input logic [15:0] mk, input logic [3:0] dw,
                              input logic ev, input logic [3:0] ech, input logic ew);
    vecs.push_back('{r, m, s, mk, dw, ev, ech, ew});
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n;
    mode  = v.mode;
    sel   = v.sel;
    mask  = v.mask;
    dwell = v.dwell;
    e.valid = v.e_valid;
    e.ch    = v.e_ch;
    e.wrap  = v.e_wrap;
    e.dout  = v.e_valid ? din_c[v.e_ch] : 1'b0;
    e.idx   = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("valid",  e.idx, 32'(valid),  32'(e.valid));
      check("ch_out", e.idx, 32'(ch_out), 32'(e.ch));
      check("dout",   e.idx, 32'(dout),   32'(e.dout));
      check("wrap",   e.idx, 32'(wrap),   32'(e.wrap));
`ifdef SCAN_MUX_PARITY_EN
      check("parity", e.idx, 32'(parity), 32'(^e.dout));
`endif
    end
  endtask

  task automatic run_sel12(input logic [3:0] s);
    logic ev;
    @(negedge clk);
    sel12 = s;
    ev = (s < 4'd12);
    @(posedge clk);
    #1;
    check("sel12.valid",  int'(s), 32'(valid12),  32'(ev));
    check("sel12.ch_out", int'(s), 32'(ch_out12), ev ? 32'(s) : 32'd0);
    check("sel12.dout",   int'(s), 32'(dout12),   ev ? 32'(din12_c[s]) : 32'd0);
    check("sel12.wrap",   int'(s), 32'(wrap12),   32'd0);
`ifdef SCAN_MUX_PARITY_EN
    check("sel12.parity", int'(s), 32'(parity12), ev ? 32'(din12_c[s]) : 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    din   = din_c;
    din12 = din12_c;
    mode  = 1'b0;
    sel   = '0;
    mask  = '0;
    dwell = '0;
    sel12 = '0;

    // Reset state
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // Manual sweep: dout follows 1,1,0,0
    for (int s = 0; s < 16; s++) add(1, 0, 4'(s), 16'h0000, 0, 1, 4'(s), 0);
    // Full scan, dwell 0
    add(1, 1, 0, 16'hFFFF, 0, 1, 0, 0);
    for (int k = 1; k < 16; k++) add(1, 1, 0, 16'hFFFF, 0, 1, 4'(k), 0);
    add(1, 1, 0, 16'hFFFF, 0, 1, 0, 1);
    add(1, 1, 0, 16'hFFFF, 0, 1, 1, 0);
    // Leave scan, then sparse scan with dwell 2
    add(1, 0, 0, 16'h0005, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 16'h0005, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 16'h0005, 2, 1, 2, 0);
    add(1, 1, 0, 16'h0005, 2, 1, 0, 1);
    add(1, 1, 0, 16'h0005, 2, 1, 0, 0);
    add(1, 1, 0, 16'h0005, 2, 1, 0, 0);
    add(1, 1, 0, 16'h0005, 2, 1, 2, 0);
    // Empty mask goes idle; single channel wraps every dwell+1; dwell change at advance
    add(1, 1, 0, 16'h0000, 2, 0, 0, 0);
    add(1, 1, 0, 16'h0000, 2, 0, 0, 0);
    add(1, 1, 0, 16'h8000, 0, 1, 15, 0);
    add(1, 1, 0, 16'h8000, 0, 1, 15, 1);
    add(1, 1, 0, 16'h8000, 1, 1, 15, 1);
    add(1, 1, 0, 16'h8000, 1, 1, 15, 0);
    add(1, 1, 0, 16'h8000, 1, 1, 15, 1);
    add(1, 1, 0, 16'h8000, 1, 1, 15, 0);
    // Mid-scan reset, then restart from lowest enabled channel
    add(1, 0, 3, 16'hFFFF, 3, 1, 3, 0);
    add(1, 1, 0, 16'hFFFF, 3, 1, 0, 0);
    add(1, 1, 0, 16'hFFFF, 3, 1, 0, 0);
    add(0, 1, 0, 16'hFFFF, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 16'hFFFF, 3, 1, 0, 0);
    add(1, 1, 0, 16'hFFFF, 3, 1, 1, 0);
    // Mask drop of current channel forces an advance
    add(1, 1, 0, 16'hFFFD, 3, 1, 2, 0);
    add(1, 1, 0, 16'hFFFD, 3, 1, 2, 0);
    add(1, 1, 0, 16'h0001, 3, 1, 0, 1);
    add(1, 1, 0, 16'h0001, 3, 1, 0, 0);
    // Mode change mid-dwell: counter restarts on re-entry
    add(1, 0, 5, 16'h0001, 3, 1, 5, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 16'h0001, 3, 1, 0, 0);
    add(1, 1, 0, 16'h0001, 3, 1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Out-of-range manual select on the 12-channel instance
    run_sel12(4'd13);
    run_sel12(4'd9);
    run_sel12(4'd12);
    run_sel12(4'd11);
    run_sel12(4'd15);
    run_sel12(4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter CHANNELS, default 16: number of input channels, 2..64.
REQ-002 SHALL have parameter DATA_W, default 1: bits per channel.
REQ-003 SHALL have parameter DWELL_W, default 4: width of the dwell count.
REQ-004 SHALL derive localparam SEL_W = clog2(CHANNELS), minimum 1.
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- din  in  CHANNELS*DATA_W  packed channels; channel k = din[k*DATA_W +: DATA_W]
- mode  in  1  0 = manual, 1 = auto-scan
- sel  in  SEL_W  manual channel select
- mask  in  CHANNELS  channel enable for scan; bit k enables channel k
- dwell  in  DWELL_W  extra cycles held per scanned channel
- dout  out  DATA_W  registered selected data
- ch_out  out  SEL_W  channel index that dout came from
- valid  out  1  dout/ch_out meaningful
- wrap  out  1  one-cycle pulse on scan wrap-around

Function
REQ-007 States SHALL be IDLE, MANUAL and SCAN; next state is evaluated every cycle from mode and mask.
REQ-008 Next-state rules SHALL be: mode=0 -> MANUAL; mode=1 with mask!=0 -> SCAN; mode=1 with mask==0 -> IDLE.
REQ-009 In MANUAL, the cycle after sel is sampled SHALL give dout = channel sel, ch_out = sel, valid = 1 (latency 1).
REQ-010 In MANUAL with sel >= CHANNELS, the next cycle SHALL give dout = 0, ch_out = 0, valid = 0.
REQ-011 On entry to SCAN, the current channel SHALL be the lowest enabled channel, and the dwell counter SHALL clear.
REQ-012 In SCAN, every cycle SHALL register dout = current channel data, ch_out = current channel, valid = 1.
REQ-013 In SCAN, each channel SHALL be held for dwell+1 cycles, then advance to the next higher enabled channel.
REQ-014 When no higher enabled channel exists, SCAN SHALL move to the lowest enabled channel and assert wrap for exactly the first cycle showing that channel.
REQ-015 If exactly one channel is enabled, SCAN SHALL hold it and pulse wrap once every dwell+1 cycles.
REQ-016 If the current channel's mask bit drops while in SCAN, the next cycle SHALL advance to the next enabled channel, regardless of dwell count.
REQ-017 A dwell change SHALL take effect at the next channel advance; a mode change SHALL take effect the next cycle and clear the dwell counter.
REQ-018 In IDLE, outputs SHALL be dout = 0, ch_out = 0, valid = 0, wrap = 0.
REQ-019 wrap SHALL be 0 outside SCAN.

Reset
REQ-020 With rst_n=0 at a rising edge: state = IDLE, dout = 0, ch_out = 0, valid = 0, wrap = 0, and the dwell counter and current channel = 0.
REQ-021 A reset asserted mid-scan SHALL abandon the scan; after release, scanning SHALL restart per REQ-011.

Configuration
REQ-022 Macro SCAN_MUX_PARITY_EN SHALL control a parity feature.
- Defined: adds output port parity (1 bit), the XOR of all dout bits, registered in the same cycle as dout; reset value 0; 0 when valid=0.
- Undefined: the parity port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-023 Package scan_mux_pkg SHALL hold the state enum (IDLE, MANUAL, SCAN) and the mode constants MODE_MANUAL = 0 and MODE_SCAN = 1.
REQ-024 Sub-module scan_mux_next SHALL be a combinational circular priority finder: given mask and the current index, it returns the next enabled index and a wrap flag.

Verification (CHANNELS=16, DATA_W=1, din=16'h3333 unless stated)
REQ-025 Manual sweep: mode=0, sel=0..15, one per cycle -> one cycle later, dout = 1,1,0,0 repeating; ch_out = sel; valid = 1.
REQ-026 Full scan: mode=1, dwell=0, mask=16'hFFFF -> ch_out = 0,1,...,15,0 on consecutive cycles; wrap = 1 only on the cycle ch_out returns to 0.
REQ-027 Sparse scan: dwell=2, mask=16'h0005 -> ch_out = 0 for 3 cycles, then 2 for 3 cycles, then 0 with wrap = 1; dout = 1,1,1,0,0,0.
REQ-028 Empty mask: mode=1, mask=0 -> valid = 0 (IDLE). Then mask=16'h8000 -> next cycle ch_out = 15, valid = 1.
REQ-029 Mid-scan reset and mask drop:
- rst_n=0 during dwell -> next edge, all outputs 0.
- Clearing the current channel's mask bit -> advance on the next cycle.
REQ-030 Out-of-range select: CHANNELS=12, mode=0, sel=13 -> dout = 0, valid = 0. With SCAN_MUX_PARITY_EN defined, parity tracks dout in all of REQ-025 to REQ-030.
